bus_endpoint: RTL and testbench
===============================

# bus_endpoint

Device-side endpoint of the multi-driver packet bus served by `bs_gnrtr_n_rbtr`. It is the other end of each bus port:
- Transmit side: a FIFO that presents `pndng`/`D_pop` to the bus and retires entries on `pop`.
- Receive side: captures packets the bus delivers with `push`/`D_push`, filters them on the destination field, and buffers them for the local device.

One instance sits on each of the `drvrs` ports of a bus instance.

## Interface
Parameters:
- `pckg_sz`, 24: packet width. Bits `[pckg_sz-1:pckg_sz-8]` carry the destination ID.
- `fifo_dpth`, 16: depth of each FIFO. Must be a power of two, at least 2.
- `id`, 0: this endpoint's 8-bit ID.
- `broadcast`, 8'b0000_0011: destination value that every endpoint accepts.

Ports:
- `clk`  in  1: single clock; all logic samples on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `pndng`  out  1: TX FIFO non-empty, to bus.
- `D_pop`  out  pckg_sz: TX FIFO head word, to bus.
- `pop`  in  1: bus consumes `D_pop` this cycle.
- `push`  in  1: bus delivers `D_push` this cycle.
- `D_push`  in  pckg_sz: packet from bus.
- `tx_wr`  in  1: device writes `tx_data`.
- `tx_data`  in  pckg_sz: packet to send.
- `tx_full`  out  1: TX FIFO full.
- `rx_rd`  in  1: device consumes `rx_data`.
- `rx_data`  out  pckg_sz: RX FIFO head word.
- `rx_vld`  out  1: RX FIFO non-empty.
- `ovf`  out  2: sticky overflow flags. Bit 0 is TX, bit 1 is RX.
- `drop_cnt`  out  8: saturating count of packets rejected by the filter.

## Operation
- Both FIFOs are first-word fall-through.
  - Each holds `fifo_dpth` entries, addressed by wrap-around read/write pointers plus an occupancy counter of width `$clog2(fifo_dpth)+1`.
  - `D_pop` and `rx_data` always show the head entry. Their value is don't-care while the FIFO is empty.
- TX FIFO:
  - `tx_wr` while not full: write `tx_data`.
  - `tx_wr` while full and `pop` in the same cycle: the write is accepted and the count is unchanged.
  - `tx_wr` while full without `pop`: the word is discarded and `ovf[0]` sets.
  - `pop` while empty: ignored; pointers unchanged.
  - `pndng` = occupancy != 0.
- RX path (one packet per `push` cycle):
  - Accept a packet when destination == `id` or destination == `broadcast`.
  - Otherwise drop it and increment `drop_cnt`, saturating at 255.
  - An accepted packet arriving while the RX FIFO is full is discarded and `ovf[1]` sets. It is not counted in `drop_cnt`.
  - A `push` while full together with `rx_rd` in the same cycle is accepted.
  - `rx_rd` while empty: ignored.
- `ovf` bits and `drop_cnt` clear only on `reset`.
- Endpoint state machine (2 bits), which gates the FIFO write enables:
  - IDLE → ACTIVE on the first cycle after reset.
  - ACTIVE → FAULT when any `ovf` bit is set.
  - FAULT keeps operating normally. It exists only so a bench can probe the state.
  - Any state → IDLE on `reset`.
  - In IDLE, `tx_wr` and `push` are ignored: the FIFOs are not written and neither `drop_cnt` nor `ovf` is updated.

## Timing
- Reset values: `pndng`=0, `tx_full`=0, `rx_vld`=0, `ovf`=0, `drop_cnt`=0, all pointers and counts 0, state IDLE.
- `D_pop` and `rx_data` after reset: the entry at pointer 0 (don't-care).
- Write-to-visibility latency is 1 cycle. `tx_wr` at edge N gives `pndng`=1 and the word on `D_pop` after edge N. `push` at edge N gives `rx_vld` after edge N.
- `pop` at edge N advances the head. The next word, or `pndng`=0, appears after edge N.
- Flags (`tx_full`, `pndng`, `rx_vld`) are registered or derived from registered occupancy. No combinational path from `pop`/`push` to any output.
- Simultaneous read and write on a non-empty, non-full FIFO: occupancy unchanged, both pointers advance.
- `reset` asserted mid-operation: all contents are lost on that edge. Inputs are ignored in the reset cycle.

## Configuration
- `ENDPOINT_FILTER_EN` defined: destination filtering on the RX path as described; `drop_cnt` is live.
- Not defined: every pushed packet is accepted regardless of destination, and `drop_cnt` is tied to 0.

## Test plan
- Reset, then 3 `tx_wr` of 0x01AAAA, 0x02BBBB, 0x03CCCC, then 3 `pop` cycles. Required: `pndng`=1 one cycle after the first write, `D_pop` sequence 0x01AAAA/0x02BBBB/0x03CCCC, `pndng`=0 after the third pop.
- `id`=1, filter enabled. Push 0x01_1234, 0x02_5678, 0x03_9ABC. Required: `rx_data` reads 0x011234 then 0x039ABC, and `drop_cnt`=1.
- 16 `tx_wr` then a 17th with no pop. Required: `tx_full`=1, 17th word absent, `ovf`=2'b01. A write while full together with `pop` is accepted and `ovf` is unaffected by that write.
- 17 accepted pushes with no `rx_rd`. Required: `ovf[1]`=1, 16 words retained in order, `drop_cnt` unchanged.
- 300 pushes to a foreign ID. Required: `drop_cnt` saturates at 255. Then assert `reset` for one cycle mid-stream. Required: all outputs return to reset values and state returns to IDLE.
- Filter compiled out: push 0x02_5678 with `id`=1. Required: accepted, `drop_cnt`=0.

Source files
------------

// File: rtl/bus_endpoint.sv
// bus_endpoint: device-side TX/RX FIFO pair for the shared packet bus.
// Define ENDPOINT_FILTER_EN to enable RX destination filtering and the drop counter.

module bus_endpoint_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_wr,
    input  logic [W-1:0]               i_wdata,
    input  logic                       i_rd,
    output logic [W-1:0]               o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_rd;
    logic          w_wr;

    assign w_full  = (r_count == FULL_CNT);
    assign w_rd    = i_rd && (r_count != '0);
    // A full FIFO still takes a write when the head retires in the same cycle.
    assign w_wr    = i_wr && (!w_full || w_rd);
    assign o_ovf   = i_wr && !w_wr;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !reset) r_mem[r_wr_ptr] <= i_wdata;
    end
endmodule

module bus_endpoint #(
    parameter int         pckg_sz   = 24,
    parameter int         fifo_dpth = 16,
    parameter logic [7:0] id        = 8'd0,
    parameter logic [7:0] broadcast = 8'b0000_0011
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    input  logic               rx_rd,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_vld,
    output logic [1:0]         ovf,
    output logic [7:0]         drop_cnt
);
    localparam int CW = $clog2(fifo_dpth) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(fifo_dpth);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_en;
    logic [1:0]    r_ovf;
    logic          w_match;
    logic          w_tx_ovf;
    logic          w_rx_ovf;
    logic [CW-1:0] w_tx_count;
    logic [CW-1:0] w_rx_count;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_en        = 1'b0;
        case (r_state)
            ST_IDLE:   w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
                w_en = 1'b1;
                if (r_ovf != '0) w_state_nxt = ST_FAULT;
            end
            ST_FAULT:  w_en = 1'b1;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef ENDPOINT_FILTER_EN
    logic [7:0] w_dst;
    logic [7:0] r_drop_cnt;

    assign w_dst   = D_push[pckg_sz-1 -: 8];
    assign w_match = (w_dst == id) || (w_dst == broadcast);

    always_ff @(posedge clk) begin
        if (reset)
            r_drop_cnt <= '0;
        else if (w_en && push && !w_match && (r_drop_cnt != '1))
            r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign w_match  = 1'b1;
    assign drop_cnt = '0;
`endif

    bus_endpoint_fifo #(
        .W     (pckg_sz),
        .DEPTH (fifo_dpth)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_wr    (tx_wr && w_en),
        .i_wdata (tx_data),
        .i_rd    (pop),
        .o_rdata (D_pop),
        .o_count (w_tx_count),
        .o_ovf   (w_tx_ovf)
    );

    bus_endpoint_fifo #(
        .W     (pckg_sz),
        .DEPTH (fifo_dpth)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_wr    (push && w_en && w_match),
        .i_wdata (D_push),
        .i_rd    (rx_rd),
        .o_rdata (rx_data),
        .o_count (w_rx_count),
        .o_ovf   (w_rx_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= '0;
        end else begin
            if (w_tx_ovf) r_ovf[0] <= 1'b1;
            if (w_rx_ovf) r_ovf[1] <= 1'b1;
        end
    end

    assign ovf     = r_ovf;
    assign pndng   = (w_tx_count != '0);
    assign tx_full = (w_tx_count == FULL_CNT);
    assign rx_vld  = (w_rx_count != '0);
endmodule

// File: tb/tb_bus_endpoint.sv
// Self-checking bench for bus_endpoint: queue-based model checked every cycle
// plus directed vectors with literal expectations.

module tb_bus_endpoint;
    localparam int W = 24;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         pndng;
    logic [W-1:0] D_pop;
    logic         pop = 1'b0;
    logic         push = 1'b0;
    logic [W-1:0] D_push = '0;
    logic         tx_wr = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_full;
    logic         rx_rd = 1'b0;
    logic [W-1:0] rx_data;
    logic         rx_vld;
    logic [1:0]   ovf;
    logic [7:0]   drop_cnt;

    always #5 clk = ~clk;

    bus_endpoint #(
        .pckg_sz   (W),
        .fifo_dpth (D),
        .id        (8'd1),
        .broadcast (8'h03)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
        .tx_full  (tx_full),
        .rx_rd    (rx_rd),
        .rx_data  (rx_data),
        .rx_vld   (rx_vld),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: queues plus sticky flags.
    logic [W-1:0] m_tx[$];
    logic [W-1:0] m_rx[$];
    logic [1:0]   m_ovf = '0;
    int           m_drop = 0;
    bit           m_idle = 1'b1;
    bit           m_valid = 1'b0;
    bit           m_txp;
    bit           m_rxp;

    function automatic bit accepts(input logic [W-1:0] p);
`ifdef ENDPOINT_FILTER_EN
        logic [7:0] dst;
        dst = p[W-1:W-8];
        return (dst == 8'd1) || (dst == 8'h03);
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_tx.delete();
            m_rx.delete();
            m_ovf   = '0;
            m_drop  = 0;
            m_idle  = 1'b1;
            m_valid = 1'b1;
        end else begin
            m_txp = pop && (m_tx.size() != 0);
            m_rxp = rx_rd && (m_rx.size() != 0);
            if (m_txp) void'(m_tx.pop_front());
            if (m_rxp) void'(m_rx.pop_front());
            if (!m_idle) begin
                if (tx_wr) begin
                    if (m_tx.size() < D) m_tx.push_back(tx_data);
                    else m_ovf[0] = 1'b1;
                end
                if (push) begin
                    if (!accepts(D_push)) begin
                        if (m_drop < 255) m_drop++;
                    end else if (m_rx.size() < D) begin
                        m_rx.push_back(D_push);
                    end else begin
                        m_ovf[1] = 1'b1;
                    end
                end
            end
            m_idle = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_pndng",   32'(pndng),   32'(m_tx.size() != 0));
            chk("m_tx_full", 32'(tx_full), 32'(m_tx.size() == D));
            if (m_tx.size() != 0) chk("m_D_pop", 32'(D_pop), 32'(m_tx[0]));
            chk("m_rx_vld",  32'(rx_vld),  32'(m_rx.size() != 0));
            if (m_rx.size() != 0) chk("m_rx_data", 32'(rx_data), 32'(m_rx[0]));
            chk("m_ovf",      32'(ovf),      32'(m_ovf));
            chk("m_drop_cnt", 32'(drop_cnt), 32'(m_drop));
        end
    end

    task automatic drive(input bit wr, input logic [W-1:0] wd, input bit p,
                         input bit ps, input logic [W-1:0] pd, input bit rd);
        tx_wr = wr; tx_data = wd; pop = p; push = ps; D_push = pd; rx_rd = rd;
        @(posedge clk); #1;
        tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and the ignored IDLE cycle
        do_reset();
        chk("rst_pndng", 32'(pndng), 32'd0);
        chk("rst_rx_vld", 32'(rx_vld), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        drive(1, 24'hFFFFFF, 0, 1, 24'h01FFFF, 0);
        chk("idle_tx_ignored", 32'(pndng), 32'd0);
        chk("idle_rx_ignored", 32'(rx_vld), 32'd0);

        // TX ordering
        drive(1, 24'h01AAAA, 0, 0, '0, 0);
        chk("t1_pndng", 32'(pndng), 32'd1);
        chk("t1_head0", 32'(D_pop), 32'h01AAAA);
        drive(1, 24'h02BBBB, 0, 0, '0, 0);
        drive(1, 24'h03CCCC, 0, 0, '0, 0);
        chk("t1_head0b", 32'(D_pop), 32'h01AAAA);
        drive(0, '0, 1, 0, '0, 0);
        chk("t1_head1", 32'(D_pop), 32'h02BBBB);
        drive(0, '0, 1, 0, '0, 0);
        chk("t1_head2", 32'(D_pop), 32'h03CCCC);
        drive(0, '0, 1, 0, '0, 0);
        chk("t1_empty", 32'(pndng), 32'd0);
        drive(0, '0, 1, 0, '0, 0);
        chk("t1_pop_empty", 32'(pndng), 32'd0);

        // RX filtering
        drive(0, '0, 0, 1, 24'h011234, 0);
        drive(0, '0, 0, 1, 24'h025678, 0);
        drive(0, '0, 0, 1, 24'h039ABC, 0);
        chk("t2_vld", 32'(rx_vld), 32'd1);
        chk("t2_head0", 32'(rx_data), 32'h011234);
        drive(0, '0, 0, 0, '0, 1);
`ifdef ENDPOINT_FILTER_EN
        chk("t2_head1", 32'(rx_data), 32'h039ABC);
        chk("t2_drop", 32'(drop_cnt), 32'd1);
        drive(0, '0, 0, 0, '0, 1);
`else
        chk("t2_head1", 32'(rx_data), 32'h025678);
        chk("t2_drop", 32'(drop_cnt), 32'd0);
        drive(0, '0, 0, 0, '0, 1);
        chk("t2_head2", 32'(rx_data), 32'h039ABC);
        drive(0, '0, 0, 0, '0, 1);
`endif
        chk("t2_drained", 32'(rx_vld), 32'd0);
        drive(0, '0, 0, 1, 24'h010001, 0);
        drive(0, '0, 0, 1, 24'h010002, 1);
        chk("t2_rw_head", 32'(rx_data), 32'h010002);
        drive(0, '0, 0, 0, '0, 1);
        chk("t2_rw_empty", 32'(rx_vld), 32'd0);

        // TX full / overflow
        do_reset();
        drive(0, '0, 0, 0, '0, 0);
        for (int i = 0; i < 16; i++) drive(1, 24'h100000 + 24'(i), 0, 0, '0, 0);
        chk("t3_full", 32'(tx_full), 32'd1);
        chk("t3_ovf0", 32'(ovf), 32'd0);
        drive(1, 24'h1000FF, 1, 0, '0, 0);
        chk("t3_full_wp", 32'(tx_full), 32'd1);
        chk("t3_ovf_wp", 32'(ovf), 32'd0);
        chk("t3_head_wp", 32'(D_pop), 32'h100001);
        drive(1, 24'h100EEE, 0, 0, '0, 0);
        chk("t3_ovf1", 32'(ovf), 32'd1);
        chk("t3_full2", 32'(tx_full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (i < 15) chk("t3_order", 32'(D_pop), 32'h100001 + 32'(i));
            else        chk("t3_order_last", 32'(D_pop), 32'h1000FF);
            drive(0, '0, 1, 0, '0, 0);
        end
        chk("t3_empty", 32'(pndng), 32'd0);
        drive(1, 24'h123456, 0, 0, '0, 0);
        chk("t3_fault_wr", 32'(D_pop), 32'h123456);
        drive(0, '0, 1, 0, '0, 0);

        // RX overflow
        do_reset();
        drive(0, '0, 0, 0, '0, 0);
        for (int i = 0; i < 17; i++) drive(0, '0, 0, 1, 24'h010000 + 24'(i), 0);
        chk("t4_ovf", 32'(ovf), 32'd2);
        chk("t4_drop", 32'(drop_cnt), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk("t4_order", 32'(rx_data), 32'h010000 + 32'(i));
            drive(0, '0, 0, 0, '0, 1);
        end
        chk("t4_empty", 32'(rx_vld), 32'd0);

        // Drop saturation, then reset mid-stream
        do_reset();
        drive(0, '0, 0, 0, '0, 0);
        drive(1, 24'h0A0A0A, 0, 0, '0, 0);
        for (int i = 0; i < 300; i++) drive(0, '0, 0, 1, 24'h050000 + 24'(i), 0);
`ifdef ENDPOINT_FILTER_EN
        chk("t5_sat", 32'(drop_cnt), 32'd255);
`else
        chk("t5_sat", 32'(drop_cnt), 32'd0);
        chk("t5_rx_ovf", 32'(ovf), 32'd2);
`endif
        tx_wr = 1'b1; tx_data = 24'h0B0B0B; push = 1'b1; D_push = 24'h057777;
        do_reset();
        tx_wr = 1'b0; push = 1'b0;
        chk("t5_rst_pndng", 32'(pndng), 32'd0);
        chk("t5_rst_full", 32'(tx_full), 32'd0);
        chk("t5_rst_vld", 32'(rx_vld), 32'd0);
        chk("t5_rst_ovf", 32'(ovf), 32'd0);
        chk("t5_rst_drop", 32'(drop_cnt), 32'd0);
        drive(1, 24'h0C0C0C, 0, 1, 24'h017777, 0);
        chk("t5_idle_tx", 32'(pndng), 32'd0);
        chk("t5_idle_rx", 32'(rx_vld), 32'd0);
        drive(0, '0, 0, 1, 24'h017777, 0);
        chk("t5_active_rx", 32'(rx_data), 32'h017777);

        // Mixed traffic, checked by the model only
        for (int i = 0; i < 80; i++) begin
            logic [7:0] dst;
            dst = 8'(1 + (i % 3));
            drive((i % 3) != 0, 24'h200000 + 24'(i), (i % 4) == 1,
                  (i % 2) == 0, {dst, 16'(i)}, (i % 5) < 2);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
